// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue logic and the multicycle mul/div unit.
interface muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              flush;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output start, alu_ctrl, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, alu_ctrl, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multicycle integer unit: shift-add MUL and restoring DIV/DIVU/REM/REMU, one iteration
// per clock, with immediate completion for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REM  = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
        return ~v + ONE;
    endfunction

    function automatic logic [DATA_W-1:0] f_abs(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? f_neg(v) : v;
    endfunction

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc, r_x, r_y, r_result;
    logic              r_neg_q, r_neg_r;

    logic              w_valid_op, w_accept, w_is_mul, w_signed, w_is_rem;
    logic              w_div0, w_ovf, w_run_mul, w_run_rem, w_ge;
    logic [DATA_W-1:0] w_early_res, w_mul_acc, w_div_rem, w_div_quo, w_final;
    logic [DATA_W:0]   w_sh;

    // Request decode; flush in IDLE only has the effect of blocking an accept.
    assign w_valid_op = (bus.alu_ctrl >= OP_MUL) && (bus.alu_ctrl <= OP_REMU);
    assign w_accept   = (r_state == IDLE) && bus.start && w_valid_op && !bus.flush;
    assign w_is_mul   = (bus.alu_ctrl == OP_MUL);
    assign w_signed   = (bus.alu_ctrl == OP_DIV) || (bus.alu_ctrl == OP_REM);
    assign w_is_rem   = (bus.alu_ctrl == OP_REM) || (bus.alu_ctrl == OP_REMU);
    assign w_div0     = !w_is_mul && (bus.op_b == '0);
    assign w_ovf      = w_signed && (bus.op_a == MIN_NEG) && (bus.op_b == '1);

    always_comb begin
        w_early_res = '0;
        if (w_div0)
            w_early_res = w_is_rem ? bus.op_a : '1;
        else if (w_ovf)
            w_early_res = w_is_rem ? '0 : bus.op_a;
    end

    // One iteration: r_x is multiplicand/divisor, r_y multiplier/dividend-to-quotient, r_acc product/remainder.
    assign w_run_mul = (r_op == OP_MUL);
    assign w_run_rem = (r_op == OP_REM) || (r_op == OP_REMU);
    assign w_mul_acc = r_acc + (r_y[0] ? r_x : '0);
    assign w_sh      = {r_acc, r_y[DATA_W-1]};
    assign w_ge      = (w_sh >= {1'b0, r_x});
    assign w_div_rem = w_ge ? (w_sh[DATA_W-1:0] - r_x) : w_sh[DATA_W-1:0];
    assign w_div_quo = {r_y[DATA_W-2:0], w_ge};

    always_comb begin
        w_final = w_div_quo;
        if (w_run_mul)
            w_final = w_mul_acc;
        else if (w_run_rem)
            w_final = r_neg_r ? f_neg(w_div_rem) : w_div_rem;
        else if (r_neg_q)
            w_final = f_neg(w_div_quo);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_div0 || w_ovf) ? DONE : RUN;
            RUN:     if (bus.flush) w_state_nxt = IDLE;
                     else if (r_cnt == LAST) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= bus.alu_ctrl;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_x     <= w_is_mul ? bus.op_a : (w_signed ? f_abs(bus.op_b) : bus.op_b);
            r_y     <= w_is_mul ? bus.op_b : (w_signed ? f_abs(bus.op_a) : bus.op_a);
            r_neg_q <= w_signed && (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1]);
            r_neg_r <= w_signed && bus.op_a[DATA_W-1];
            if (w_div0 || w_ovf)
                r_result <= w_early_res;
        end else if (r_state == RUN && !bus.flush) begin
            r_acc <= w_run_mul ? w_mul_acc : w_div_rem;
            r_x   <= w_run_mul ? (r_x << 1) : r_x;
            r_y   <= w_run_mul ? (r_y >> 1) : w_div_quo;
            if (r_cnt != LAST)
                r_cnt <= r_cnt + CNT_ONE;
            else
                r_result <= w_final;
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == DONE) && !bus.flush;
    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, early-out cases, flush and reset.
module tb_muldiv_unit;
    localparam logic [3:0] MUL = 4'b1010, DIV = 4'b1011, DIVU = 4'b1100, REM = 4'b1101, REMU = 4'b1110;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_unit_if #(.DATA_W(32)) bus ();

    muldiv_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to its done pulse; exp_lat counts edges after the accept edge.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int nbusy;
        bus.start    = 1'b1;
        bus.alu_ctrl = op;
        bus.op_a     = a;
        bus.op_b     = b;
        tick();
        bus.start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) nbusy++;
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, bus.result, exp_res);
        if (bus.busy) nbusy++;
        tick();
        chk({tag, "_end"}, {30'd0, bus.busy, bus.done}, 32'd0);
        chk({tag, "_busycyc"}, 32'(nbusy), 32'(exp_lat + 1));
    endtask

    initial begin
        int ndone;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.alu_ctrl = 4'b0000;
        bus.op_a     = '0;
        bus.op_b     = '0;
        tick();
        tick();
        chk("reset_state", {29'd0, bus.busy, bus.done, 1'b0}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("mul_7_neg3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
        run_op("mul_m1_m1", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32);
        run_op("mul_ovf_lo", MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 32);
        run_op("div_m20_3", DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 32);
        run_op("rem_m20_3", REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 32);
        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 32);
        run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 32);
        run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
        run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 32);
        run_op("div_m7_m2", DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32);
        run_op("rem_m7_m2", REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32);
        run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32);
        run_op("remu_max_16", REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 32);
        run_op("divu_5_7", DIVU, 32'd5, 32'd7, 32'd0, 32);
        run_op("divu_by0", DIVU, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("remu_by0", REMU, 32'h8000_0000, 32'd0, 32'h8000_0000, 0);
        run_op("rem_by0", REM, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFEC, 0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

        // Unsupported opcodes must not start anything.
        bus.start    = 1'b1;
        bus.alu_ctrl = 4'b1111;
        bus.op_a     = 32'd9;
        bus.op_b     = 32'd3;
        tick();
        bus.alu_ctrl = 4'b0010;
        tick();
        bus.start = 1'b0;
        chk("badop_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("badop_result", bus.result, 32'd0);

        // Start while busy is ignored.
        bus.start    = 1'b1;
        bus.alu_ctrl = MUL;
        bus.op_a     = 32'd5;
        bus.op_b     = 32'd6;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) begin
                bus.start    = 1'b1;
                bus.alu_ctrl = DIV;
                bus.op_a     = 32'd9;
                bus.op_b     = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) ndone++;
            tick();
        end
        chk("busy_start_res", bus.result, 32'd30);
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_idle", {31'd0, bus.busy}, 32'd0);

        // Flush mid-run abandons the operation and keeps the old result.
        bus.start    = 1'b1;
        bus.alu_ctrl = DIVU;
        bus.op_a     = 32'd1000;
        bus.op_b     = 32'd10;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("flush_result", bus.result, 32'd30);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) ndone++;
            tick();
        end
        chk("flush_nodone", 32'(ndone), 32'd0);
        run_op("mul_2_3", MUL, 32'd2, 32'd3, 32'd6, 32);

        // Flush during the DONE cycle masks the pulse.
        bus.start    = 1'b1;
        bus.alu_ctrl = DIVU;
        bus.op_a     = 32'd4;
        bus.op_b     = 32'd0;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b1;
        #1;
        chk("flush_done_mask", {31'd0, bus.done}, 32'd0);
        tick();
        bus.flush = 1'b0;
        chk("flush_done_idle", {31'd0, bus.busy}, 32'd0);

        // Flush and start together in IDLE: no accept.
        bus.start    = 1'b1;
        bus.flush    = 1'b1;
        bus.alu_ctrl = MUL;
        bus.op_a     = 32'd3;
        bus.op_b     = 32'd3;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_idle", {31'd0, bus.busy}, 32'd0);

        // Reset mid-run, start held during reset, bad opcode after release.
        bus.start    = 1'b1;
        bus.alu_ctrl = MUL;
        bus.op_a     = 32'd11;
        bus.op_b     = 32'd13;
        tick();
        for (int c = 1; c < 12; c++) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_run_state", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("rst_run_result", bus.result, 32'd0);
        tick();
        chk("rst_start_held", {31'd0, bus.busy}, 32'd0);
        rst_n        = 1'b1;
        bus.alu_ctrl = 4'b0010;
        tick();
        bus.start = 1'b0;
        chk("rst_badop_idle", {31'd0, bus.busy}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) ndone++;
            tick();
        end
        chk("rst_nodone", 32'(ndone), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
